key_autorepeat: RTL



---
 rtl/tetris_input_pkg.sv | 21 ++
 rtl/key_autorepeat.sv | 106 ++++++++++
 2 files changed

// File: rtl/tetris_input_pkg.sv
// Shared types and defaults for the tetris key input path (debouncer -> autorepeat -> game).
package tetris_input_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } ar_state_e;

  localparam int CLK_HZ_DEFAULT     = 25_000_000;
  localparam int DAS_DELAY_DEFAULT  = 4_000_000;
  localparam int ARR_PERIOD_DEFAULT = 1_250_000;
  localparam int CNT_W_DEFAULT      = 22;

  localparam logic [7:0] REPEATS_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == REPEATS_MAX) ? REPEATS_MAX : v + 8'd1;
  endfunction

endpackage

// File: rtl/key_autorepeat.sv
// Delayed auto-shift for one key: a move on press, another after DAS_DELAY,
// then one every ARR_PERIOD until release or until the game stops accepting input.
module key_autorepeat
  import tetris_input_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int DAS_DELAY  = DAS_DELAY_DEFAULT,
  parameter int ARR_PERIOD = ARR_PERIOD_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pressed,
  input  logic       released,
  input  logic       enable,
  output logic       move,
  output logic       held,
  output logic [7:0] repeats
);

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  if (CLK_HZ < 1 || DAS_DELAY < 2 || ARR_PERIOD < 2 ||
      longint'(DAS_DELAY) > (longint'(1) << CNT_W) ||
      longint'(ARR_PERIOD) > (longint'(1) << CNT_W)) begin : g_bad_param
    $error("key_autorepeat: illegal parameter combination");
  end

  ar_state_e        state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             move_q, move_d;
  logic             held_q, held_d;
  logic [7:0]       repeats_q, repeats_d;

  // Next-state logic: enable > released > pressed > timer expiry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    move_d    = 1'b0;
    repeats_d = repeats_q;
    if (!enable) begin
      state_d = IDLE;
      timer_d = CNT_ZERO;
    end else if (released) begin
      state_d = IDLE;
      timer_d = CNT_ZERO;
    end else if (pressed) begin
      state_d   = DELAY;
      timer_d   = CNT_ZERO;
      move_d    = 1'b1;
      repeats_d = 8'd1;
    end else begin
      case (state_q)
        DELAY: begin
          if (timer_q == DAS_LAST) begin
            state_d   = REPEAT;
            timer_d   = CNT_ZERO;
            move_d    = 1'b1;
            repeats_d = sat_inc(repeats_q);
          end else begin
            timer_d = timer_q + CNT_ONE;
          end
        end
        REPEAT: begin
          if (timer_q == ARR_LAST) begin
            timer_d   = CNT_ZERO;
            move_d    = 1'b1;
            repeats_d = sat_inc(repeats_q);
          end else begin
            timer_d = timer_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = CNT_ZERO;
        end
      endcase
    end
    held_d = (state_d != IDLE);
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= CNT_ZERO;
      move_q    <= 1'b0;
      held_q    <= 1'b0;
      repeats_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      move_q    <= move_d;
      held_q    <= held_d;
      repeats_q <= repeats_d;
    end
  end

  assign move    = move_q;
  assign held    = held_q;
  assign repeats = repeats_q;

endmodule
